// File: rtl/bram_pixel_reader.sv
// bram_pixel_reader: streams a BRAM-held RGB444 frame as raster greyscale pixels.
// Build option READER_LOOP_EN: after the last read, restart the frame without a new start.
module bram_pixel_reader #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int BIT_DEPTH    = 12,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk_100mhz,
  input  logic                            sys_rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] rd_addr,
  output logic                            rd_en,
  input  logic [BIT_DEPTH-1:0]            rd_data,
  output logic [7:0]                      pixel_out,
  output logic [$clog2(WIDTH)-1:0]        pixel_x,
  output logic [$clog2(HEIGHT)-1:0]       pixel_y,
  output logic                            pixel_last,
  output logic                            pixel_valid,
  input  logic                            pixel_ready
);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_addr;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_pl;
  logic [XW-1:0]           r_px [READ_LATENCY];
  logic [YW-1:0]           r_py [READ_LATENCY];

  logic [7:0]    r_fpix [FIFO_DEPTH];
  logic [XW-1:0] r_fx   [FIFO_DEPTH];
  logic [YW-1:0] r_fy   [FIFO_DEPTH];
  logic          r_fl   [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_done;

  logic [CW-1:0] w_inflight;
  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_rd_en;
  logic          w_last_addr;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_r;
  logic [3:0]    w_g;
  logic [3:0]    w_b;
  logic [7:0]    w_grey;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // count words still travelling through the BRAM read pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  assign w_used      = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_credit    = w_used < (CW+1)'(FIFO_DEPTH);
  assign w_rd_en     = (r_state == S_READ) && w_credit;
  assign w_last_addr = (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));
  assign w_push      = r_vld[READ_LATENCY-1];
  assign w_pop       = pixel_valid && pixel_ready;

  assign w_r    = rd_data[11:8];
  assign w_g    = rd_data[7:4];
  assign w_b    = rd_data[3:0];
  assign w_grey = ({4'd0, w_r} * 8'd5)
                + ({4'd0, w_g} * 8'd9)
                + ({4'd0, w_b} * 8'd2);

  assign rd_en       = w_rd_en;
  assign rd_addr     = r_addr;
  assign busy        = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done        = r_done;
  assign pixel_valid = (r_count != '0);
  assign pixel_out   = r_fpix[r_rptr];
  assign pixel_x     = r_fx[r_rptr];
  assign pixel_y     = r_fy[r_rptr];
  assign pixel_last  = r_fl[r_rptr];

  // state register
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state: read until the last address, drain, pulse done
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ: begin
`ifdef READER_LOOP_EN
        w_next = S_READ;
`else
        if (w_rd_en && w_last_addr) w_next = S_DRAIN;
`endif
      end
      S_DRAIN: if (w_pop && pixel_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // raster address counter; wraps to 0 after the last read
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_rd_en) begin
      if (w_last_addr) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (r_x == XW'(WIDTH - 1)) begin
        r_addr <= r_addr + AW'(1);
        r_x    <= '0;
        r_y    <= r_y + YW'(1);
      end else begin
        r_addr <= r_addr + AW'(1);
        r_x    <= r_x + XW'(1);
      end
    end
  end

  // read-valid and coordinate tags matched to the BRAM latency
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_vld <= '0;
      r_pl  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_en;
      r_pl[0]  <= w_last_addr;
      r_px[0]  <= r_x;
      r_py[0]  <= r_y;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pl[i]  <= r_pl[i-1];
        r_px[i]  <= r_px[i-1];
        r_py[i]  <= r_py[i-1];
      end
    end
  end

  // output FIFO; returned words are converted to grey on entry
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fpix[i] <= '0;
        r_fx[i]   <= '0;
        r_fy[i]   <= '0;
        r_fl[i]   <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fpix[r_wptr] <= w_grey;
        r_fx[r_wptr]   <= r_px[READ_LATENCY-1];
        r_fy[r_wptr]   <= r_py[READ_LATENCY-1];
        r_fl[r_wptr]   <= r_pl[READ_LATENCY-1];
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // done pulses the cycle after the final pixel handshake
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) r_done <= 1'b0;
    else         r_done <= w_pop && pixel_last;
  end

endmodule

// File: tb/tb_bram_pixel_reader.sv
// tb_bram_pixel_reader: directed tests of the BRAM frame reader.
// Uses a 32x16 frame so every scenario stays short.
module tb_bram_pixel_reader;
  localparam int W  = 32;
  localparam int H  = 16;
  localparam int P  = W * H;
  localparam int L  = 2;
  localparam int FD = 4;

  typedef struct packed {
    logic [7:0] p;
    logic [4:0] x;
    logic [3:0] y;
    logic       l;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] rd_addr;
  logic       rd_en;
  logic [11:0] rd_data;
  logic [7:0] pixel_out;
  logic [4:0] pixel_x;
  logic [3:0] pixel_y;
  logic       pixel_last;
  logic       pixel_valid;

  bram_pixel_reader #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(12),
    .READ_LATENCY(L), .FIFO_DEPTH(FD)
  ) dut (
    .clk_100mhz (clk),
    .sys_rst    (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .pixel_out  (pixel_out),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_last (pixel_last),
    .pixel_valid(pixel_valid),
    .pixel_ready(ready)
  );

  always #5 clk = ~clk;

  // two-cycle BRAM read model
  logic [11:0] mem [P];
  logic [11:0] d1 = '0;
  logic [11:0] d2 = '0;
  always @(posedge clk) begin
    if (rd_en) d1 <= mem[rd_addr];
    d2 <= d1;
  end
  assign rd_data = d2;

  int n_pass = 0;
  int n_tot  = 0;

  pix_t q[$];
  int issued, popped, max_out, done_cnt, done_cyc;
  int first_valid, first_pop, last_pop, stall_issued;
  int bad_addr, busy_drop;
  logic c1_busy, c1_rd_en, busy_at_done;
  logic [8:0] c1_addr;

  function automatic pix_t exp_pix(input int i);
    pix_t e;
    int k;
    logic [11:0] w;
    k = i % P;
    w = mem[k];
    e.p = 8'(5 * int'(w[11:8]) + 9 * int'(w[7:4]) + 2 * int'(w[3:0]));
    e.x = 5'(k % W);
    e.y = 4'(k / W);
    e.l = (k == P - 1);
    return e;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < P; i++) mem[i] = 12'(i);
  endtask

  // collect handshakes after a start driven at the previous negedge
  task automatic recv(input int mode, input int frames, input int max_cyc);
    q.delete();
    issued = 0; popped = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
    first_valid = -1; first_pop = -1; last_pop = -1; stall_issued = -1;
    bad_addr = 0; busy_drop = 0;
    c1_busy = 1'b0; c1_rd_en = 1'b0; c1_addr = '1; busy_at_done = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = (c == 100);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 9) < 3);
        default: ready = (c > 50);
      endcase
      if (c == 1) begin
        c1_busy = busy; c1_rd_en = rd_en; c1_addr = rd_addr;
      end
      if (rd_en) begin
        if (int'(rd_addr) != issued % P) bad_addr++;
        issued++;
      end
      if (c == 50) stall_issued = issued;
      if (pixel_valid && first_valid < 0) first_valid = c;
      if (pixel_valid && ready) begin
        q.push_back({pixel_out, pixel_x, pixel_y, pixel_last});
        popped++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) begin
        done_cnt++; done_cyc = c; busy_at_done = busy;
        if (done_cnt == frames) break;
      end else if (!busy) begin
        busy_drop++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tot++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
    else n_pass++;
    n_tot++;
    if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done);
    else n_pass++;
    n_tot++;
    if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", rd_en);
    else n_pass++;
    n_tot++;
    if (rd_addr !== 9'd0) $display("FAIL reset_rd_addr got %0d exp 0", rd_addr);
    else n_pass++;
    n_tot++;
    if (pixel_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", pixel_valid);
    else n_pass++;
    n_tot++;
    if ({pixel_out, pixel_x, pixel_y, pixel_last} !== 18'd0)
      $display("FAIL reset_pixel got %h exp 0", {pixel_out, pixel_x, pixel_y, pixel_last});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int errs;
    load_ramp();
    @(negedge clk); start = 1'b1;
    recv(0, 1, 2000);
    n_tot++;
    if ({c1_busy, c1_rd_en} !== 2'b11)
      $display("FAIL basic_first_cycle got busy=%b rd_en=%b exp 1 1", c1_busy, c1_rd_en);
    else n_pass++;
    n_tot++;
    if (c1_addr !== 9'd0) $display("FAIL basic_first_addr got %0d exp 0", c1_addr);
    else n_pass++;
    n_tot++;
    if (first_valid != 4) $display("FAIL basic_first_valid got %0d exp 4", first_valid);
    else n_pass++;
    n_tot++;
    if (q.size() != P) $display("FAIL basic_count got %0d exp %0d", q.size(), P);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== exp_pix(i)) errs++;
    n_tot++;
    if (errs != 0) $display("FAIL basic_sequence got %0d bad pixels exp 0", errs);
    else n_pass++;
    n_tot++;
    if (q[31] !== {8'd39, 5'd31, 4'd0, 1'b0})
      $display("FAIL basic_row_end got %h exp %h", q[31], {8'd39, 5'd31, 4'd0, 1'b0});
    else n_pass++;
    n_tot++;
    if (q[32] !== {8'd18, 5'd0, 4'd1, 1'b0})
      $display("FAIL basic_row_wrap got %h exp %h", q[32], {8'd18, 5'd0, 4'd1, 1'b0});
    else n_pass++;
    n_tot++;
    if (q[291] !== {8'd29, 5'd3, 4'd9, 1'b0})
      $display("FAIL basic_px291 got %h exp %h", q[291], {8'd29, 5'd3, 4'd9, 1'b0});
    else n_pass++;
    n_tot++;
    if (q[511] !== {8'd170, 5'd31, 4'd15, 1'b1})
      $display("FAIL basic_last got %h exp %h", q[511], {8'd170, 5'd31, 4'd15, 1'b1});
    else n_pass++;
    n_tot++;
    if (done_cyc != P + L + 2)
      $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, P + L + 2);
    else n_pass++;
    n_tot++;
    if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done got %b exp 0", busy_at_done);
    else n_pass++;
    n_tot++;
    if (busy_drop != 0) $display("FAIL basic_busy_drop got %0d exp 0", busy_drop);
    else n_pass++;
    n_tot++;
    if (bad_addr != 0 || issued != P)
      $display("FAIL basic_reads got bad=%0d n=%0d exp 0 %0d", bad_addr, issued, P);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if ({done, busy} !== 2'b00)
      $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_grey_extremes();
    load_ramp();
    mem[0] = 12'hFFF; mem[1] = 12'h000; mem[2] = 12'hF00;
    @(negedge clk); start = 1'b1;
    recv(0, 1, 2000);
    n_tot++;
    if (q[0].p !== 8'd240) $display("FAIL grey_fff got %0d exp 240", q[0].p);
    else n_pass++;
    n_tot++;
    if (q[1].p !== 8'd0) $display("FAIL grey_000 got %0d exp 0", q[1].p);
    else n_pass++;
    n_tot++;
    if (q[2].p !== 8'd75) $display("FAIL grey_f00 got %0d exp 75", q[2].p);
    else n_pass++;
    load_ramp();
  endtask

  task automatic test_backpressure();
    int errs;
    @(negedge clk); start = 1'b1;
    recv(1, 1, 20000);
    n_tot++;
    if (q.size() != P || done_cnt != 1)
      $display("FAIL bp_count got %0d done=%0d exp %0d 1", q.size(), done_cnt, P);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== exp_pix(i)) errs++;
    n_tot++;
    if (errs != 0) $display("FAIL bp_sequence got %0d bad pixels exp 0", errs);
    else n_pass++;
    n_tot++;
    if (max_out > FD) $display("FAIL bp_outstanding got %0d exp <= %0d", max_out, FD);
    else n_pass++;
    n_tot++;
    if (bad_addr != 0 || issued != P)
      $display("FAIL bp_reads got bad=%0d n=%0d exp 0 %0d", bad_addr, issued, P);
    else n_pass++;
  endtask

  task automatic test_stall_start();
    int errs;
    @(negedge clk); start = 1'b1;
    recv(2, 1, 3000);
    n_tot++;
    if (stall_issued != FD) $display("FAIL stall_reads got %0d exp %0d", stall_issued, FD);
    else n_pass++;
    n_tot++;
    if (first_pop != 51) $display("FAIL stall_first_pop got %0d exp 51", first_pop);
    else n_pass++;
    n_tot++;
    if (q[0] !== {8'd0, 5'd0, 4'd0, 1'b0}) $display("FAIL stall_first_pixel got %h exp 0", q[0]);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== exp_pix(i)) errs++;
    n_tot++;
    if (errs != 0 || q.size() != P)
      $display("FAIL stall_sequence got %0d bad n=%0d exp 0 %0d", errs, q.size(), P);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    int errs;
    cnt = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 2000 && cnt < 300; c++) begin
      @(negedge clk);
      start = 1'b0; ready = 1'b1;
      if (pixel_valid) cnt++;
    end
    n_tot++;
    if (cnt != 300) $display("FAIL rstmid_reach got %0d exp 300", cnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_tot++;
    if ({busy, done, rd_en, pixel_valid} !== 4'b0000)
      $display("FAIL rstmid_ctrl got %b exp 0000", {busy, done, rd_en, pixel_valid});
    else n_pass++;
    n_tot++;
    if ({rd_addr, pixel_out, pixel_x, pixel_y, pixel_last} !== 27'd0)
      $display("FAIL rstmid_data got %h exp 0", {rd_addr, pixel_out, pixel_x, pixel_y, pixel_last});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    n_tot++;
    if ({busy, rd_en, pixel_valid} !== 3'b000)
      $display("FAIL rstmid_idle got %b exp 000", {busy, rd_en, pixel_valid});
    else n_pass++;
    start = 1'b1;
    recv(0, 1, 2000);
    errs = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== exp_pix(i)) errs++;
    n_tot++;
    if (errs != 0 || q.size() != P)
      $display("FAIL rstmid_frame got %0d bad n=%0d exp 0 %0d", errs, q.size(), P);
    else n_pass++;
    n_tot++;
    if (done_cyc != P + L + 2)
      $display("FAIL rstmid_done got %0d exp %0d", done_cyc, P + L + 2);
    else n_pass++;
  endtask

`ifdef READER_LOOP_EN
  task automatic test_loop();
    int errs;
    load_ramp();
    @(negedge clk); start = 1'b1;
    recv(0, 2, 3 * P);
    n_tot++;
    if (q.size() != 2 * P) $display("FAIL loop_count got %0d exp %0d", q.size(), 2 * P);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== exp_pix(i)) errs++;
    n_tot++;
    if (errs != 0) $display("FAIL loop_sequence got %0d bad pixels exp 0", errs);
    else n_pass++;
    n_tot++;
    if (done_cnt != 2) $display("FAIL loop_done_count got %0d exp 2", done_cnt);
    else n_pass++;
    n_tot++;
    if (busy_drop != 0 || busy_at_done !== 1'b1)
      $display("FAIL loop_busy got drop=%0d at_done=%b exp 0 1", busy_drop, busy_at_done);
    else n_pass++;
    n_tot++;
    if (last_pop - first_pop != 2 * P - 1)
      $display("FAIL loop_gapless got %0d exp %0d", last_pop - first_pop, 2 * P - 1);
    else n_pass++;
    n_tot++;
    if (bad_addr != 0) $display("FAIL loop_reads got %0d bad exp 0", bad_addr);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    load_ramp();
    test_reset();
`ifdef READER_LOOP_EN
    test_loop();
`else
    test_basic();
    test_grey_extremes();
    test_backpressure();
    test_stall_start();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bram_pixel_reader.md
# bram_pixel_reader

Streams a stored WIDTH×HEIGHT RGB444 frame out of a single-port-read BRAM (the read port of the image/pyramid buffers) as a raster-ordered 8-bit greyscale pixel stream with valid/ready handshake. It is the read-side counterpart of the frame writers: it issues BRAM addresses, absorbs the fixed BRAM read latency, and applies backpressure with a small credit-controlled FIFO. The stream feeds the Gaussian pyramid and blur stages.

## Interface
- WIDTH, 128, frame width in pixels
- HEIGHT, 128, frame height in pixels
- BIT_DEPTH, 12, BRAM word width (RGB444: [11:8]=R, [7:4]=G, [3:0]=B)
- READ_LATENCY, 2, BRAM address-to-data cycles (1 or 2)
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ READ_LATENCY+2
- clk_100mhz  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  begin frame read; sampled only in IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last pixel handshake
- rd_addr  out  $clog2(WIDTH*HEIGHT)  BRAM read address
- rd_en  out  1  BRAM read enable (drives enb)
- rd_data  in  BIT_DEPTH  BRAM read data, valid READ_LATENCY cycles after rd_en
- pixel_out  out  8  greyscale pixel
- pixel_x  out  $clog2(WIDTH)  column of pixel_out
- pixel_y  out  $clog2(HEIGHT)  row of pixel_out
- pixel_last  out  1  high with the final pixel of the frame
- pixel_valid  out  1  stream valid
- pixel_ready  in  1  downstream ready

## Operation
- States: IDLE → READ (start=1) → DRAIN (last address issued) → DONE (last pixel handshaken, one cycle) → IDLE.
- READ: rd_en=1 and rd_addr increments by 1 only when credits allow: (fifo_count + in_flight) < FIFO_DEPTH. rd_addr = x + WIDTH*y, starting at 0, ending at WIDTH*HEIGHT-1.
- in_flight tracked by a READ_LATENCY-deep valid shift register of rd_en; returned words are written to the FIFO unconditionally (credits guarantee no overflow).
- Greyscale on FIFO write: grey = 5R + 9G + 2B, 8-bit result, max 240, no saturation needed. x/y and last travel with the pixel in the FIFO.
- Output: pixel_valid = FIFO non-empty; pop on pixel_valid && pixel_ready. pixel_out/x/y/last stable while valid && !ready.
- DRAIN: no reads; wait for FIFO empty and in_flight=0 with final pop.
- start in any non-IDLE state ignored.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, pixel_valid=0, pixel_out=0, pixel_x=0, pixel_y=0, pixel_last=0; FIFO and pipeline flushed; state IDLE.
- Reset mid-frame: all in-flight data discarded; next frame begins only on new start.

## Timing
- start high at edge N (IDLE) → busy=1 and first rd_en with rd_addr=0 in cycle N+1.
- First pixel_valid in cycle N+1+READ_LATENCY+1 (one register stage after data returns).
- pixel_ready held high: one pixel per cycle sustained, no bubbles; frame of WIDTH*HEIGHT pixels completes in WIDTH*HEIGHT + READ_LATENCY + 2 cycles after start.
- pixel_ready low: reads stall within FIFO_DEPTH issued-but-unpopped words; no data lost, no duplicate.
- done pulses the cycle after the pixel_last handshake; busy falls in the same cycle.
- Row wrap: x=WIDTH-1 → x=0, y+1; pixel_last at x=WIDTH-1, y=HEIGHT-1.
- Simultaneous FIFO push and pop on the same edge: count unchanged, both take effect.

## Configuration
- READER_LOOP_EN defined: after the last address is issued, rd_addr wraps to 0 and READ continues without a new start; done still pulses per frame and busy stays high until sys_rst; credit rule unchanged, no gap between frames when ready=1.
- Undefined: single-shot frame as above; IDLE after DONE.

## Test plan
- Basic frame: BRAM preloaded with addr[11:0], ready=1, start pulse → 16384 pixels in raster order, pixel_out = 5R+9G+2B of each word, last at (127,127), done one cycle after.
- Greyscale extremes: words 12'hFFF, 12'h000, 12'hF00 → 240, 0, 75.
- Backpressure: ready toggled randomly 30% high → identical pixel sequence to basic frame, FIFO never exceeds FIFO_DEPTH, no rd_en issued when credits exhausted.
- Stall at start: ready=0 for 50 cycles after start → exactly FIFO_DEPTH reads issued, then first pixel (addr 0) on ready rise.
- Reset mid-frame: sys_rst at pixel 5000 → all outputs to reset values asynchronously; subsequent start yields full frame from (0,0).
- READER_LOOP_EN: two consecutive frames with ready=1 → pixel (0,0) of frame 2 directly follows pixel_last of frame 1, done pulses twice, busy stays 1.
